// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width: clog2(width), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (output start, a, b, cin, input busy, done, sum, cout, overflow);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, overflow);
endinterface

// File: rtl/serial_adder_full_adder2.sv
// One-bit full adder cell composed of two half adders.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder2 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit add, one bit per clock LSB first, start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           reset,
  serial_adder_if.slave bus
);
  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             accept, last_bit;

  full_adder2 u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign last_bit = (cnt == LAST);
  // Concatenate-then-shift keeps the WIDTH=1 case free of reversed slices.
  assign res_nx   = WIDTH'({fa_sum, res_sr} >> 1);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN:  if (last_bit) state_nx = ST_DONE;
      ST_DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        carry  <= bus.cin;
        cnt    <= '0;
        res_sr <= '0;
      end else if (state == ST_RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_nx;
        carry  <= fa_cout;
        cnt    <= cnt + 1'b1;
        if (last_bit) begin
          // carry still holds the carry into the MSB on this edge
          bus.sum      <= res_nx;
          bus.cout     <= fa_cout;
          bus.overflow <= carry ^ fa_cout;
        end
      end
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);

endmodule
